// File: rtl/neuron_pkg.sv
// Shared types and width helpers for the neuron family (hidden and output neurons).
// The accumulator width is derived here so that every neuron variant sizes identically.
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        ACT
    } state_t;

    function automatic int clog2(input int value);
        int res;
        int pow;
        res = 0;
        pow = 1;
        while (pow < value) begin
            pow = pow * 2;
            res = res + 1;
        end
        return res;
    endfunction

    // One product plus sign bit, or the bias, whichever is wider, grown by log2 of the term count.
    function automatic int acc_width(input int x_w, input int w_w, input int b_w, input int n_in);
        int base;
        base = ((x_w + w_w + 1) > b_w) ? (x_w + w_w + 1) : b_w;
        return base + clog2(n_in) + 1;
    endfunction

endpackage

// File: rtl/neuron_act.sv
// Activation: ReLU with unsigned saturation, or signed saturation, of the accumulator.
// Purely combinational; the caller registers the result.
module neuron_act #(
    parameter int ACC_W   = 12,
    parameter int OUT_W   = 10,
    parameter int RELU_EN = 1
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [OUT_W-1:0] result
);

    // Compare in a width that holds both the accumulator and the output limits.
    localparam int CMP_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 2;
    localparam logic        [CMP_W-1:0] ONE   = CMP_W'(1);
    localparam logic signed [CMP_W-1:0] U_MAX = $signed((ONE << OUT_W) - ONE);
    localparam logic signed [CMP_W-1:0] S_MAX = $signed((ONE << (OUT_W - 1)) - ONE);
    localparam logic signed [CMP_W-1:0] S_MIN = ~S_MAX;

    logic signed [CMP_W-1:0] acc_x;
    logic signed [CMP_W-1:0] clip;

    assign acc_x = CMP_W'(acc);

    always_comb begin
        clip = acc_x;
        if (RELU_EN != 0) begin
            if (acc_x[CMP_W-1]) begin
                clip = '0;
            end else if (acc_x > U_MAX) begin
                clip = U_MAX;
            end
        end else begin
            if (acc_x > S_MAX) begin
                clip = S_MAX;
            end else if (acc_x < S_MIN) begin
                clip = S_MIN;
            end
        end
    end

    assign result = OUT_W'(clip);

endmodule

// File: rtl/mac_neuron.sv
// Serial multiply-accumulate neuron: bias plus N_IN products through one multiplier, then activation.
// Start accepted in IDLE; result and done pulse N_IN+1 enabled edges later; en_i low freezes everything.
module mac_neuron
    import neuron_pkg::*;
#(
    parameter int N_IN    = 4,
    parameter int X_W     = 4,
    parameter int W_W     = 4,
    parameter int B_W     = 8,
    parameter int OUT_W   = 10,
    parameter int RELU_EN = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic                    start_i,
    input  logic [N_IN*X_W-1:0]     x_i,
    input  logic [N_IN*W_W-1:0]     w_i,
    input  logic signed [B_W-1:0]   bias_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [OUT_W-1:0]        neuron_o
);

    localparam int ACC_W = acc_width(X_W, W_W, B_W, N_IN);
    localparam int IDX_W = clog2(N_IN);
    localparam int P_W   = X_W + W_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

    state_t                   state_q;
    state_t                   state_d;
    logic                     load;
    logic [X_W-1:0]           x_q [N_IN];
    logic [W_W-1:0]           w_q [N_IN];
    logic signed [ACC_W-1:0]  acc_q;
    logic [IDX_W-1:0]         idx_q;
    logic                     done_q;
    logic [OUT_W-1:0]         neuron_q;
    logic [OUT_W-1:0]         act_res;
    logic signed [X_W:0]      x_sel;
    logic signed [W_W-1:0]    w_sel;
    logic signed [P_W-1:0]    prod;

    // Unsigned input gets a zero sign bit so the product is a plain signed multiply.
    assign x_sel = $signed({1'b0, x_q[idx_q]});
    assign w_sel = $signed(w_q[idx_q]);
    assign prod  = P_W'(x_sel) * P_W'(w_sel);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        if (en_i) begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d = ACCUM;
                        load    = 1'b1;
                    end
                end
                ACCUM: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ACT;
                    end
                end
                ACT:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The bias goes straight into the accumulator, which doubles as its latch.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k < N_IN; k++) begin
                x_q[k] <= '0;
                w_q[k] <= '0;
            end
            acc_q    <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            neuron_q <= '0;
        end else if (en_i) begin
            done_q <= 1'b0;
            if (load) begin
                for (int k = 0; k < N_IN; k++) begin
                    x_q[k] <= x_i[k*X_W +: X_W];
                    w_q[k] <= w_i[k*W_W +: W_W];
                end
                acc_q <= ACC_W'(bias_i);
                idx_q <= '0;
            end else if (state_q == ACCUM) begin
                acc_q <= acc_q + ACC_W'(prod);
                idx_q <= idx_q + 1'b1;
            end else if (state_q == ACT) begin
                neuron_q <= act_res;
                done_q   <= 1'b1;
                idx_q    <= '0;
            end
        end
    end

    neuron_act #(
        .ACC_W   (ACC_W),
        .OUT_W   (OUT_W),
        .RELU_EN (RELU_EN)
    ) u_act (
        .acc    (acc_q),
        .result (act_res)
    );

    assign busy_o   = (state_q != IDLE);
    assign done_o   = done_q;
    assign neuron_o = neuron_q;

endmodule

// File: tb/tb_mac_neuron.sv
// Self-checking bench: four parameter variants share stimulus and are compared to an arithmetic model.
module tb_mac_neuron;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        start;
    logic [15:0] x_bus;
    logic [15:0] w_bus;
    logic [7:0]  bias;

    logic        busy_a, busy_s, busy_8, busy_8s;
    logic        done_a, done_s, done_8, done_8s;
    logic [9:0]  neu_a, neu_s;
    logic [7:0]  neu_8, neu_8s;
    logic [9:0]  res [4];

    logic [3:0]        xa [4];
    logic signed [3:0] wa [4];
    logic signed [7:0] ba;

    int ow [4] = '{10, 10, 8, 8};
    int rl [4] = '{1, 0, 1, 0};

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mac_neuron #(.OUT_W(10), .RELU_EN(1)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .en_i(en), .start_i(start), .x_i(x_bus), .w_i(w_bus),
        .bias_i(bias), .busy_o(busy_a), .done_o(done_a), .neuron_o(neu_a));
    mac_neuron #(.OUT_W(10), .RELU_EN(0)) dut_s (
        .clk_i(clk), .rst_i(rst_n), .en_i(en), .start_i(start), .x_i(x_bus), .w_i(w_bus),
        .bias_i(bias), .busy_o(busy_s), .done_o(done_s), .neuron_o(neu_s));
    mac_neuron #(.OUT_W(8), .RELU_EN(1)) dut_8 (
        .clk_i(clk), .rst_i(rst_n), .en_i(en), .start_i(start), .x_i(x_bus), .w_i(w_bus),
        .bias_i(bias), .busy_o(busy_8), .done_o(done_8), .neuron_o(neu_8));
    mac_neuron #(.OUT_W(8), .RELU_EN(0)) dut_8s (
        .clk_i(clk), .rst_i(rst_n), .en_i(en), .start_i(start), .x_i(x_bus), .w_i(w_bus),
        .bias_i(bias), .busy_o(busy_8s), .done_o(done_8s), .neuron_o(neu_8s));

    assign res[0] = neu_a;
    assign res[1] = neu_s;
    assign res[2] = {2'b00, neu_8};
    assign res[3] = {2'b00, neu_8s};

    wire all_done = done_a & done_s & done_8 & done_8s;
    wire any_done = done_a | done_s | done_8 | done_8s;
    wire all_busy = busy_a & busy_s & busy_8 & busy_8s;
    wire any_busy = busy_a | busy_s | busy_8 | busy_8s;

    // Reference: bias plus the dot product, then the activation rules with plain integers.
    function automatic longint model_acc();
        longint s;
        s = longint'(ba);
        for (int k = 0; k < 4; k++) s += longint'(xa[k]) * longint'(wa[k]);
        return s;
    endfunction

    function automatic logic [9:0] model_act(input longint a, input int width, input int relu);
        longint mx, mn, r;
        if (relu != 0) begin
            mx = (longint'(1) << width) - 1;
            r  = (a < 0) ? 0 : ((a > mx) ? mx : a);
        end else begin
            mx = (longint'(1) << (width - 1)) - 1;
            mn = -mx - 1;
            r  = (a > mx) ? mx : ((a < mn) ? mn : a);
            r  = r & ((longint'(1) << width) - 1);
        end
        return 10'(r);
    endfunction

    task automatic set_inputs();
        for (int k = 0; k < 4; k++) begin
            x_bus[k*4 +: 4] = xa[k];
            w_bus[k*4 +: 4] = wa[k];
        end
        bias = ba;
    endtask

    task automatic set_vec(input int x0, x1, x2, x3, input int w0, w1, w2, w3, input int b);
        xa[0] = 4'(x0); xa[1] = 4'(x1); xa[2] = 4'(x2); xa[3] = 4'(x3);
        wa[0] = 4'(w0); wa[1] = 4'(w1); wa[2] = 4'(w2); wa[3] = 4'(w3);
        ba = 8'(b);
        set_inputs();
    endtask

    // Pulses start for one edge and counts negedges until done is seen (bounded).
    task automatic run_vec(output int cyc, output bit ok);
        start = 1'b1;
        cyc = 0;
        ok = 1'b0;
        while (!ok && cyc < 60) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (done_a) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (any_busy !== 1'b0 || any_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy=%b done=%b, required 0 0", any_busy, any_done);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (res[k] !== 10'd0) begin
                n_fail++;
                $display("FAIL reset_out[%0d]: got %0d, required 0", k, res[k]);
            end
        end
    endtask

    task automatic test_basic();
        int cyc;
        int busy_cnt;
        bit ok;
        longint a;
        set_vec(1, 2, 3, 4, 1, 2, 3, 4, 0);
        a = model_acc();
        start = 1'b1;
        cyc = 0;
        ok = 1'b0;
        busy_cnt = 0;
        while (!ok && cyc < 60) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (all_busy) busy_cnt++;
            if (all_done) ok = 1'b1;
        end
        n_checks++;
        if (!ok || cyc != 6) begin
            n_fail++;
            $display("FAIL basic_latency: done after %0d cycles (seen=%b), required 6", cyc, ok);
        end
        n_checks++;
        if (busy_cnt != 5) begin
            n_fail++;
            $display("FAIL basic_busy: busy for %0d cycles, required 5", busy_cnt);
        end
        n_checks++;
        if (neu_a !== 10'd30) begin
            n_fail++;
            $display("FAIL basic_value: got %0d, required 30", neu_a);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (res[k] !== model_act(a, ow[k], rl[k])) begin
                n_fail++;
                $display("FAIL basic_out[%0d]: got %0d, required %0d", k, res[k], model_act(a, ow[k], rl[k]));
            end
        end
        @(negedge clk);
        n_checks++;
        if (any_done !== 1'b0 || res[0] !== 10'd30) begin
            n_fail++;
            $display("FAIL basic_pulse: done=%b out=%0d one cycle later, required 0 30", any_done, res[0]);
        end
    endtask

    task automatic test_vector(input string name);
        int cyc;
        bit ok;
        longint a;
        a = model_acc();
        run_vec(cyc, ok);
        n_checks++;
        if (!ok || cyc != 6) begin
            n_fail++;
            $display("FAIL %s_latency: %0d cycles (seen=%b), required 6", name, cyc, ok);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (res[k] !== model_act(a, ow[k], rl[k])) begin
                n_fail++;
                $display("FAIL %s_out[%0d]: got %0d, required %0d acc=%0d", name, k, res[k],
                         model_act(a, ow[k], rl[k]), a);
            end
        end
    endtask

    task automatic test_neg_and_sat();
        set_vec(1, 2, 3, 4, -1, -2, -3, -4, 5);
        test_vector("neg");
        n_checks++;
        if (neu_a !== 10'd0 || neu_s !== 10'h3E7) begin
            n_fail++;
            $display("FAIL neg_const: relu=%0h signed=%0h, required 0 3e7", neu_a, neu_s);
        end
        set_vec(15, 15, 15, 15, 7, 7, 7, 7, 127);
        test_vector("sat_pos");
        n_checks++;
        if (neu_8 !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_pos_const: got %0d, required 255", neu_8);
        end
        set_vec(15, 15, 15, 15, -8, -8, -8, -8, 127);
        test_vector("sat_neg");
        n_checks++;
        if (neu_8s !== 8'h80) begin
            n_fail++;
            $display("FAIL sat_neg_const: got %0h, required 80", neu_8s);
        end
    endtask

    task automatic test_stall();
        int cyc;
        bit ok;
        set_vec(1, 2, 3, 4, 1, 2, 3, 4, 0);
        start = 1'b1;
        cyc = 0;
        ok = 1'b0;
        while (!ok && cyc < 60) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (cyc == 2) begin
                en = 1'b0;
                x_bus = 16'hFFFF;
                w_bus = 16'h7777;
            end
            if (cyc == 5) en = 1'b1;
            if (done_a) ok = 1'b1;
        end
        n_checks++;
        if (!ok || cyc != 9) begin
            n_fail++;
            $display("FAIL stall_latency: %0d cycles (seen=%b), required 9", cyc, ok);
        end
        n_checks++;
        if (neu_a !== 10'd30) begin
            n_fail++;
            $display("FAIL stall_value: got %0d, required 30", neu_a);
        end
        en = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (all_done !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_done_hold: done=%b while disabled, required 1", all_done);
        end
        en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (any_done !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_done_clear: done=%b after enabled edge, required 0", any_done);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_a [4];
        logic [9:0] exp_b [4];
        int cyc;
        bit ok;
        longint a;
        set_vec(5, 9, 15, 2, 3, -7, 6, -8, -20);
        a = model_acc();
        for (int k = 0; k < 4; k++) exp_b[k] = model_act(a, ow[k], rl[k]);
        set_vec(1, 2, 3, 4, 1, 2, 3, 4, 0);
        a = model_acc();
        for (int k = 0; k < 4; k++) exp_a[k] = model_act(a, ow[k], rl[k]);
        start = 1'b1;
        for (int r = 0; r < 6; r++) begin
            cyc = 0;
            ok = 1'b0;
            while (!ok && cyc < 60) begin
                @(negedge clk);
                cyc++;
                if (done_a) begin
                    ok = 1'b1;
                end else begin
                    x_bus = 16'($urandom);
                    w_bus = 16'($urandom);
                    bias  = 8'($urandom);
                end
            end
            n_checks++;
            if (!ok || cyc != 6) begin
                n_fail++;
                $display("FAIL b2b_interval[%0d]: %0d cycles (seen=%b), required 6", r, cyc, ok);
            end
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (res[k] !== ((r % 2 == 0) ? exp_a[k] : exp_b[k])) begin
                    n_fail++;
                    $display("FAIL b2b_out[%0d][%0d]: got %0d, required %0d", r, k, res[k],
                             (r % 2 == 0) ? exp_a[k] : exp_b[k]);
                end
            end
            if (r % 2 == 0) set_vec(5, 9, 15, 2, 3, -7, 6, -8, -20);
            else            set_vec(1, 2, 3, 4, 1, 2, 3, 4, 0);
        end
        start = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        set_vec(15, 15, 15, 15, 7, 7, 7, 7, 127);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (any_busy !== 1'b0 || any_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_ctrl: busy=%b done=%b, required 0 0", any_busy, any_done);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (res[k] !== 10'd0) begin
                n_fail++;
                $display("FAIL midrst_out[%0d]: got %0d, required 0", k, res[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_vec(1, 2, 3, 4, 1, 2, 3, 4, 0);
        test_vector("post_rst");
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 4; k++) begin
                xa[k] = 4'($urandom);
                wa[k] = 4'($urandom);
            end
            ba = 8'($urandom);
            set_inputs();
            test_vector("rand");
            @(negedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        start = 1'b0;
        x_bus = '0;
        w_bus = '0;
        bias  = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_basic();
        test_neg_and_sat();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
